// File: rtl/ariane_pkg.sv
// Shared divider types: operator encodings, FSM states and operator helpers.
// The seq_divider fast path is enabled by defining SEQ_DIV_FASTPATH_EN.
package ariane_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  function automatic logic op_signed(
    input div_op_e op
  );
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_rem(
    input div_op_e op
  );
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring division step on a partial remainder / quotient
// pair; the quotient register also carries the remaining dividend bits.
module div_step
  import ariane_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_i < div_i, so the shifted value fits in XLEN+1 bits and the
  // top bit of diff is a clean borrow flag.
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, div_i};
    if (diff[XLEN]) begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end else begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 integer divider (DIV/DIVU/REM/REMU) with valid/ready.
// Define SEQ_DIV_FASTPATH_EN to finish trivial operands early.
module seq_divider
  import ariane_pkg::*;
#(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     div_valid_i,
  output logic                     div_ready_o,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  div_op_e                  operator_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  output logic                     div_valid_o,
  input  logic                     out_ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] div_trans_id_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  div_state_e               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [XLEN-1:0]          rem_q, rem_d;
  logic [XLEN-1:0]          quo_q, quo_d;
  logic [XLEN-1:0]          dvs_q, dvs_d;
  div_op_e                  op_q, op_d;
  logic [TRANS_ID_BITS-1:0] id_q, id_d;
  logic                     negq_q, negq_d;
  logic                     negr_q, negr_d;
  logic                     dz_q, dz_d;
  logic                     ovf_q, ovf_d;
  logic                     fast_q, fast_d;
  logic                     valid_q, valid_d;
  logic [XLEN-1:0]          result_q, result_d;

  logic                     accept;
  logic                     a_neg;
  logic                     b_neg;
  logic [XLEN-1:0]          mag_a;
  logic [XLEN-1:0]          mag_b;
  logic                     acc_dz;
  logic                     acc_ovf;
  logic                     acc_fast;
  logic [XLEN-1:0]          step_rem;
  logic [XLEN-1:0]          step_quo;

  div_step #(
    .XLEN (XLEN)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  function automatic logic [XLEN-1:0] fix_res(
    input div_op_e         op,
    input logic [XLEN-1:0] quo,
    input logic [XLEN-1:0] rem,
    input logic            negq,
    input logic            negr,
    input logic            dz,
    input logic            ovf
  );
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    q = negq ? (~quo + 1'b1) : quo;
    r = negr ? (~rem + 1'b1) : rem;
    unique case (1'b1)
      ovf: begin
        q = MIN_NEG;
        r = '0;
      end
      dz:      q = '1;
      default: ;
    endcase
    return op_rem(op) ? r : q;
  endfunction

  always_comb begin
    a_neg   = op_signed(operator_i) & operand_a_i[XLEN-1];
    b_neg   = op_signed(operator_i) & operand_b_i[XLEN-1];
    mag_a   = a_neg ? (~operand_a_i + 1'b1) : operand_a_i;
    mag_b   = b_neg ? (~operand_b_i + 1'b1) : operand_b_i;
    acc_dz  = (operand_b_i == '0);
    acc_ovf = op_signed(operator_i)
            & (operand_a_i == MIN_NEG)
            & (operand_b_i == '1);
`ifdef SEQ_DIV_FASTPATH_EN
    acc_fast = acc_dz | acc_ovf | (operand_a_i == '0);
`else
    acc_fast = 1'b0;
`endif
  end

  assign accept = div_valid_i & (state_q == IDLE) & ~flush_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    op_d     = op_q;
    id_d     = id_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    fast_d   = fast_q;
    valid_d  = valid_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DIVIDE;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = mag_a;
          dvs_d   = mag_b;
          op_d    = operator_i;
          id_d    = trans_id_i;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          dz_d    = acc_dz;
          ovf_d   = acc_ovf;
          fast_d  = acc_fast;
        end
      end
      DIVIDE: begin
        if (fast_q) begin
          // untouched dividend magnitude serves as the remainder
          state_d  = FINISH;
          valid_d  = 1'b1;
          result_d = fix_res(op_q, '0, quo_q,
                             negq_q, negr_q, dz_q, ovf_q);
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = FINISH;
            valid_d  = 1'b1;
            cnt_d    = '0;
            result_d = fix_res(op_q, step_quo, step_rem,
                               negq_q, negr_q, dz_q, ovf_q);
          end
        end
      end
      FINISH: begin
        if (out_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      op_q     <= DIV;
      id_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      fast_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      op_q     <= op_d;
      id_q     <= id_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      fast_q   <= fast_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign div_ready_o    = (state_q == IDLE);
  assign div_valid_o    = valid_q;
  assign result_o       = result_q;
  assign div_trans_id_o = id_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (XLEN=64).
// Latency expectations follow SEQ_DIV_FASTPATH_EN when it is defined.
module tb_seq_divider;
  import ariane_pkg::*;

  localparam int XL = 64;
`ifdef SEQ_DIV_FASTPATH_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          div_valid_i;
  logic          div_ready_o;
  logic [3:0]    trans_id_i;
  div_op_e       operator_i;
  logic [XL-1:0] operand_a_i;
  logic [XL-1:0] operand_b_i;
  logic          div_valid_o;
  logic          out_ready_i;
  logic [XL-1:0] result_o;
  logic [3:0]    div_trans_id_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_divider #(
    .XLEN          (XL),
    .TRANS_ID_BITS (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .div_valid_i    (div_valid_i),
    .div_ready_o    (div_ready_o),
    .trans_id_i     (trans_id_i),
    .operator_i     (operator_i),
    .operand_a_i    (operand_a_i),
    .operand_b_i    (operand_b_i),
    .div_valid_o    (div_valid_o),
    .out_ready_i    (out_ready_i),
    .result_o       (result_o),
    .div_trans_id_o (div_trans_id_o)
  );

  task automatic check_eq(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(
    input div_op_e     op,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [3:0]  id
  );
    div_valid_i = 1'b1;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    trans_id_i  = id;
    @(posedge clk); #1;
    div_valid_i = 1'b0;
    operand_a_i = '0;
    operand_b_i = '0;
    trans_id_i  = '0;
  endtask

  task automatic run_op(
    input string       tag,
    input div_op_e     op,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [3:0]  id,
    input logic [63:0] exp,
    input bit          fast,
    input int          hold
  );
    int n;
    int lat;
    lat = (FP && fast) ? 1 : XL;
    check_eq({tag, "/ready"}, 64'(div_ready_o), 64'd1);
    send(op, a, b, id);
    n = 0;
    while (!div_valid_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "/latency"}, 64'(n), 64'(lat));
    check_eq({tag, "/result"}, result_o, exp);
    check_eq({tag, "/id"}, 64'(div_trans_id_o), 64'(id));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "/hold_v"}, 64'(div_valid_o), 64'd1);
      check_eq({tag, "/hold_r"}, result_o, exp);
      check_eq({tag, "/hold_id"}, 64'(div_trans_id_o), 64'(id));
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    check_eq({tag, "/drop_v"}, 64'(div_valid_o), 64'd0);
    check_eq({tag, "/idle"}, 64'(div_ready_o), 64'd1);
  endtask

  task automatic no_valid_for(input string tag, input int cyc);
    int seen;
    seen = 0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      if (div_valid_o) seen++;
    end
    check_eq(tag, 64'(seen), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "/ready"}, 64'(div_ready_o), 64'd1);
    check_eq({tag, "/valid"}, 64'(div_valid_o), 64'd0);
    check_eq({tag, "/result"}, result_o, 64'd0);
    check_eq({tag, "/id"}, 64'(div_trans_id_o), 64'd0);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] M3   = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] M2   = 64'hFFFF_FFFF_FFFF_FFFE;

  initial begin
    int n;
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    div_valid_i = 1'b0;
    trans_id_i  = '0;
    operator_i  = DIV;
    operand_a_i = '0;
    operand_b_i = '0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_reset_vals("reset");

    run_op("divu_100_7", DIVU, 64'd100, 64'd7, 4'd3, 64'd14, 1'b0, 0);
    run_op("remu_100_7", REMU, 64'd100, 64'd7, 4'd4, 64'd2, 1'b0, 0);
    run_op("rem_m7_2", REM, M7, 64'd2, 4'd1, ONES, 1'b0, 0);
    run_op("div_m7_2", DIV, M7, 64'd2, 4'd2, M3, 1'b0, 0);
    run_op("div_7_m2", DIV, 64'd7, M2, 4'd6, M3, 1'b0, 0);
    run_op("rem_7_m2", REM, 64'd7, M2, 4'd7, 64'd1, 1'b0, 0);
    run_op("divu_ones_1", DIVU, ONES, 64'd1, 4'd8, ONES, 1'b0, 0);
    run_op("div_5_0", DIV, 64'd5, 64'd0, 4'd9, ONES, 1'b1, 0);
    run_op("remu_5_0", REMU, 64'd5, 64'd0, 4'd10, 64'd5, 1'b1, 0);
    run_op("rem_m7_0", REM, M7, 64'd0, 4'd11, M7, 1'b1, 0);
    run_op("div_ovf", DIV, MINN, ONES, 4'd12, MINN, 1'b1, 0);
    run_op("rem_ovf", REM, MINN, ONES, 4'd13, 64'd0, 1'b1, 0);
    run_op("div_0_9", DIV, 64'd0, 64'd9, 4'd14, 64'd0, 1'b1, 0);
    run_op("hold10", DIVU, 64'd1000, 64'd10, 4'd15, 64'd100, 1'b0, 10);

    // flush during iteration 20 of an operation
    send(DIVU, 64'd100, 64'd7, 4'd5);
    repeat (19) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check_eq("flush/valid", 64'(div_valid_o), 64'd0);
    check_eq("flush/ready", 64'(div_ready_o), 64'd1);
    no_valid_for("flush/stale", 80);
    run_op("after_flush", DIVU, 64'd100, 64'd7, 4'd3, 64'd14, 1'b0, 0);

    // flush beats a same-cycle request
    flush_i     = 1'b1;
    div_valid_i = 1'b1;
    operator_i  = DIVU;
    operand_a_i = 64'd9;
    operand_b_i = 64'd3;
    trans_id_i  = 4'd9;
    @(posedge clk); #1;
    flush_i     = 1'b0;
    div_valid_i = 1'b0;
    check_eq("flush_req/ready", 64'(div_ready_o), 64'd1);
    no_valid_for("flush_req/stale", 70);

    // flush beats out_ready in FINISH
    send(DIVU, 64'd50, 64'd5, 4'd2);
    n = 0;
    while (!div_valid_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("fin_flush/lat", 64'(n), 64'(XL));
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    check_eq("fin_flush/valid", 64'(div_valid_o), 64'd0);
    check_eq("fin_flush/ready", 64'(div_ready_o), 64'd1);

    // reset in the middle of DIVIDE
    send(DIV, 64'd77, 64'd7, 4'd6);
    repeat (30) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check_reset_vals("mid_reset");
    no_valid_for("mid_reset/stale", 80);
    run_op("after_reset", DIV, 64'd77, 64'd7, 4'd6, 64'd11, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width.
REQ-002 SHALL have parameter TRANS_ID_BITS, default 4, transaction-ID width.
REQ-003 SHALL have clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have flush_i  in  1  abort any in-flight operation.
REQ-006 SHALL have div_valid_i  in  1  request valid.
REQ-007 SHALL have div_ready_o  out  1  request may be accepted.
REQ-008 SHALL have trans_id_i  in  TRANS_ID_BITS  request ID.
REQ-009 SHALL have operator_i  in  div_op_e  DIV, DIVU, REM or REMU.
REQ-010 SHALL have operand_a_i / operand_b_i  in  XLEN each  dividend / divisor.
REQ-011 SHALL have div_valid_o  out  1  result valid.
REQ-012 SHALL have out_ready_i  in  1  consumer accepts result.
REQ-013 SHALL have result_o  out  XLEN  quotient or remainder.
REQ-014 SHALL have div_trans_id_o  out  TRANS_ID_BITS  ID of the result.

Function
REQ-015 SHALL implement FSM IDLE -> DIVIDE -> FINISH -> IDLE.
REQ-016 SHALL assert div_ready_o only in IDLE; acceptance = div_valid_i & div_ready_o.
REQ-017 SHALL, on acceptance, latch ID and operator, convert signed operands to magnitudes and enter DIVIDE.
REQ-018 SHALL perform one radix-2 restoring step per cycle in DIVIDE, for exactly XLEN cycles (6-bit counter for XLEN=64).
REQ-019 SHALL assert div_valid_o in FINISH, first in the cycle following edge T+XLEN, where T is the acceptance edge.
REQ-020 SHALL hold result_o and div_trans_id_o stable while div_valid_o & ~out_ready_i.
REQ-021 SHALL go FINISH -> IDLE on out_ready_i; a new request is accepted no earlier than the next cycle.
REQ-022 SHALL give signed quotient negative iff operand signs differ; signed remainder takes the dividend's sign.
REQ-023 SHALL return on divisor 0: quotient all-ones, remainder = operand_a_i (RISC-V rule).
REQ-024 SHALL return on signed overflow (most-negative / -1): quotient = most-negative, remainder 0.
REQ-025 SHALL, on flush_i in any state, go to IDLE next cycle with div_valid_o low and the result discarded; flush_i overrides a same-cycle request and out_ready_i.

Reset
REQ-026 SHALL, with rst_i high at a clock edge, set IDLE, counter 0, div_valid_o 0, result_o 0, div_trans_id_o 0, div_ready_o 1 in the following cycle.
REQ-027 SHALL abandon a mid-operation reset completely; no stale result appears afterwards.

Configuration
REQ-028 SHALL honour macro SEQ_DIV_FASTPATH_EN.
REQ-029 SHALL, when defined, send divide-by-zero, signed overflow and operand_a_i == 0 from acceptance straight to FINISH; div_valid_o rises after edge T+1.
REQ-030 SHALL, when undefined, run all operands for the full XLEN iterations; results are identical in both builds and only latency differs.

Structure
REQ-031 SHALL take typedef div_op_e and the encodings DIV=0, DIVU=1, REM=2, REMU=3 from ariane_pkg.
REQ-032 SHALL put the single combinational shift/subtract iteration in sub-module div_step; the FSM, counter and sign handling stay in seq_divider.

Verification
REQ-033 SHALL cover DIVU 100 / 7, ID 3 -> result 14, ID 3, valid after edge T+64.
REQ-034 SHALL cover REM -7 / 2 -> result -1 (all-ones); DIV -7 / 2 -> -3.
REQ-035 SHALL cover DIV 5 / 0 -> all-ones; REMU 5 / 0 -> 5; with SEQ_DIV_FASTPATH_EN, valid after edge T+1.
REQ-036 SHALL cover DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same operands -> 0.
REQ-037 SHALL cover flush_i at iteration 20 -> no div_valid_o, div_ready_o high next cycle; the next request completes correctly.
REQ-038 SHALL cover out_ready_i held low 10 cycles -> result and ID stable with div_valid_o high; rst_i asserted mid-DIVIDE -> all outputs at reset values.
